nn_input_feeder: RTL and testbench



---
 rtl/nn_input_feeder.sv | 142 ++++++++++++++
 tb/tb_nn_input_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_input_feeder.sv
// rtl/nn_input_feeder.sv - circular operand buffer streaming programmed bursts over valid/ready
//
// Host writes land in a DEPTH-entry circular buffer. A start command with a legal
// length streams that many beats to the accelerator. If the buffer runs dry mid-burst,
// the block waits for more host writes.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   wr_en, wr_data    host write strobe and operand
//   full, empty       buffer occupancy flags
//   start, len        burst request and its beat count (1..DEPTH), sampled together
//   valid, data       beat offered to the accelerator (data is 0 when valid is 0)
//   ready             accelerator accepts the offered beat
//   busy, done        burst in progress; one-cycle pulse after the final beat
//   err_overflow      sticky flag: a write was attempted while full
module nn_input_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic              err_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     beats_left_q, beats_left_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic wr_accept;
    logic xfer;
    logic len_ok;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign valid     = (state_q == SEND) && !empty;
    assign data      = valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_overflow = err_q;

    // Full is judged on the pre-edge count, so a transfer in the same cycle
    // does not make room for a write.
    assign wr_accept = wr_en && !full;
    assign xfer      = valid && ready;
    assign len_ok    = (len != '0) && (len <= DEPTH_C);

    always_comb begin
        wr_ptr_d = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = xfer ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_accept, xfer})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        err_d = err_q || (wr_en && full);
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    state_d      = SEND;
                    beats_left_d = len;
                end
            end
            SEND: begin
                if (xfer) begin
                    beats_left_d = beats_left_q - CNT_ONE;
                    if (beats_left_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // busy and done are registered copies of the next-state decode.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            beats_left_q <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beats_left_q <= beats_left_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_nn_input_feeder.sv
// tb/tb_nn_input_feeder.sv - self-checking bench for nn_input_feeder
module tb_nn_input_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              ready = 1'b0;
    logic              full, empty, valid, busy, done, err_overflow;
    logic [DATA_W-1:0] data;

    always #5 clk = ~clk;

    nn_input_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .start(start), .len(len),
        .valid(valid), .data(data), .ready(ready), .busy(busy),
        .done(done), .err_overflow(err_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of buffered operands plus burst bookkeeping.
    logic [DATA_W-1:0] mq[$];
    bit m_send, m_done, m_err;
    int m_beats;

    typedef struct {
        bit we; logic [7:0] wd; bit st; int ln; bit rd;
        bit v; logic [7:0] d; bit f; bit e; bit b; bit dn;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_valid();
        return m_send && (mq.size() > 0);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_send = 0; m_done = 0; m_err = 0; m_beats = 0;
    endtask

    task automatic m_step();
        bit xf, wok;
        xf  = m_valid() && ready;
        wok = wr_en && (mq.size() < DEPTH);
        if (wr_en && !wok) m_err = 1;
        if (xf) void'(mq.pop_front());
        if (wok) mq.push_back(wr_data);
        if (m_done) begin
            m_done = 0;
        end else if (m_send) begin
            if (xf) begin
                m_beats--;
                if (m_beats == 0) begin
                    m_send = 0;
                    m_done = 1;
                end
            end
        end else if (start && len >= 1 && len <= DEPTH) begin
            m_send  = 1;
            m_beats = int'(len);
        end
    endtask

    task automatic check_model();
        chk("model_valid", valid, m_valid());
        chk("model_data", data, m_valid() ? mq[0] : 8'h00);
        chk("model_full", full, mq.size() == DEPTH);
        chk("model_empty", empty, mq.size() == 0);
        chk("model_busy", busy, m_send || m_done);
        chk("model_done", done, m_done);
        chk("model_err", err_overflow, m_err);
    endtask

    task automatic drive(input bit we, input logic [7:0] wd, input bit st, input int ln, input bit rd);
        wr_en = we; wr_data = wd; start = st; len = ln[ADDR_W:0]; ready = rd;
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic cyc(input bit we, input logic [7:0] wd, input bit st, input int ln, input bit rd);
        drive(we, wd, st, ln, rd);
        sample();
        advance();
    endtask

    // Called at posedge+1: asserts reset between edges, checks the immediate effect.
    task automatic async_reset();
        drive(0, 8'h00, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_overflow, 0);
        m_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic vec_t mk(bit we, logic [7:0] wd, bit st, int ln, bit rd,
                                bit v, logic [7:0] d, bit f, bit e, bit b, bit dn);
        vec_t r;
        r.we = we; r.wd = wd; r.st = st; r.ln = ln; r.rd = rd;
        r.v = v; r.d = d; r.f = f; r.e = e; r.b = b; r.dn = dn;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;

        //           we  wd     st ln rd   v  d      f  e  b  dn
        tbl.push_back(mk(1, 8'h11, 0, 0, 0,  0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h44, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3, 1,  0, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h11, 1, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h22, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h33, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(mk(1, 8'h55, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 2, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  1, 8'h44, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  1, 8'h44, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  1, 8'h44, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h44, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h55, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 1, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 5, 0,  0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 1, 0, 0));

        // Reset state
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 0);
        chk("reset_full", full, 0);
        chk("reset_empty", empty, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err_overflow, 0);
        reset = 1'b1;

        // Table: basic burst, back-pressure, illegal lengths
        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wd, tbl[i].st, tbl[i].ln, tbl[i].rd);
            sample();
            chk($sformatf("row%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("row%0d_data", i), data, tbl[i].d);
            chk($sformatf("row%0d_full", i), full, tbl[i].f);
            chk($sformatf("row%0d_empty", i), empty, tbl[i].e);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].b);
            chk($sformatf("row%0d_done", i), done, tbl[i].dn);
            advance();
        end

        // Underrun: burst of 2 on an empty buffer
        cyc(0, 8'h00, 1, 2, 1);
        drive(1, 8'hA5, 0, 0, 1); sample();
        chk("underrun_wait_valid", valid, 0);
        chk("underrun_wait_busy", busy, 1);
        advance();
        drive(0, 8'h00, 0, 0, 1); sample();
        chk("underrun_first_valid", valid, 1);
        chk("underrun_first_data", data, 8'hA5);
        advance();
        drive(1, 8'h5A, 0, 0, 1); sample();
        chk("underrun_gap_valid", valid, 0);
        chk("underrun_gap_done", done, 0);
        advance();
        drive(0, 8'h00, 0, 0, 1); sample();
        chk("underrun_second_data", data, 8'h5A);
        advance();
        drive(0, 8'h00, 0, 0, 1); sample();
        chk("underrun_done", done, 1);
        advance();
        cyc(0, 8'h00, 0, 0, 0);

        // Overflow alongside a transfer, then write+transfer from non-full
        cyc(1, 8'h61, 0, 0, 0);
        cyc(1, 8'h62, 0, 0, 0);
        cyc(1, 8'h63, 0, 0, 0);
        cyc(1, 8'h64, 1, 4, 0);
        drive(1, 8'h77, 0, 0, 1); sample();
        chk("ovf_full_before", full, 1);
        chk("ovf_head", data, 8'h61);
        advance();
        drive(1, 8'h88, 0, 0, 1); sample();
        chk("ovf_err", err_overflow, 1);
        chk("ovf_not_full", full, 0);
        chk("ovf_head2", data, 8'h62);
        advance();
        drive(0, 8'h00, 0, 0, 1); sample();
        chk("simul_not_full", full, 0);
        chk("simul_head3", data, 8'h63);
        advance();
        drive(0, 8'h00, 0, 0, 1); sample();
        chk("simul_head4", data, 8'h64);
        advance();
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 1, 1, 1);
        drive(0, 8'h00, 0, 0, 1); sample();
        chk("wrap_readback", data, 8'h88);
        advance();
        cyc(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 0); sample();
        chk("wrap_drained", empty, 1);
        advance();

        // start pulsed during SEND is ignored
        cyc(1, 8'h91, 0, 0, 0);
        cyc(1, 8'h92, 1, 1, 0);
        dones = 0;
        cyc(0, 8'h00, 1, 2, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 8'h00, 0, 0, 1);
            sample();
            if (done === 1'b1) dones++;
            advance();
        end
        chk("start_in_send_dones", dones, 1);
        chk("start_in_send_left", empty, 0);

        // Reset mid-burst
        cyc(1, 8'hB1, 0, 0, 0);
        cyc(1, 8'hB2, 1, 3, 1);
        cyc(0, 8'h00, 0, 0, 1);
        async_reset();
        for (int k = 0; k < 3; k++) cyc(0, 8'h00, 0, 0, 1);
        cyc(1, 8'hC1, 0, 0, 0);
        cyc(0, 8'h00, 1, 1, 1);
        drive(0, 8'h00, 0, 0, 1); sample();
        chk("post_reset_data", data, 8'hC1);
        advance();
        cyc(0, 8'h00, 0, 0, 1);

        // Randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 4) == 0,
                    int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
